hold_controller: RTL and testbench

- Sequential owner of the Tetris hold slot. Sits directly upstream of the hold-region pixel driver and supplies its hold_piece_type.
- Arbitrates the player's hold request against the falling piece.
- Handshakes a replacement spawn with the game FSM.
- Enforces the once-per-drop hold rule.

---
 rtl/hold_controller_pkg.sv | 29 ++
 rtl/hold_controller.sv | 152 +++++++++++++++
 tb/tb_hold_controller.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hold_controller_pkg.sv
// Shared game types used by the hold slot controller and the hold pixel driver.
package hold_controller_pkg;

   // Tetromino / tile identity; BLANK marks an empty cell or an empty hold slot.
   typedef enum logic [2:0] {
      BLANK  = 3'd0,
      TILE_I = 3'd1,
      TILE_O = 3'd2,
      TILE_T = 3'd3,
      TILE_S = 3'd4,
      TILE_Z = 3'd5,
      TILE_J = 3'd6,
      TILE_L = 3'd7
   } tile_type_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SPAWN   = 2'd1,
      LOCKOUT = 2'd2
   } hold_state_t;

   localparam int unsigned HOLD_SPAWN_TIMEOUT_DEFAULT = 16;
   localparam int unsigned HOLD_CNT_W                 = 8;

   function automatic logic is_blank(input tile_type_t t);
      return (t == BLANK);
   endfunction

endpackage

// File: rtl/hold_controller.sv
// Hold slot owner: swaps the falling piece with the held piece via a spawn
// handshake with the game FSM and exposes the held type to the hold display.
// Optional macro HOLD_LOCKOUT_EN: when defined, only one hold is allowed per
// dropped piece (LOCKOUT state, hold_used driven); otherwise holds may repeat.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a hold button edge while a piece is falling
// SPAWN   | spawn_req asserted, waiting for spawn_ack or timeout
// LOCKOUT | swap done, further holds ignored until the piece locks
module hold_controller
   import hold_controller_pkg::*;
#(
   parameter int unsigned SPAWN_TIMEOUT = HOLD_SPAWN_TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       game_clear,
   input  logic       hold_btn,
   input  logic       falling_valid,
   input  tile_type_t falling_type,
   input  logic       piece_locked,
   input  logic       spawn_ack,
   output logic       spawn_req,
   output logic       spawn_from_queue,
   output tile_type_t spawn_type,
   output tile_type_t hold_piece_type,
   output logic       hold_used,
   output logic       hold_abort
);

   // Last counter value before the swap gives up; the request is then high
   // for exactly SPAWN_TIMEOUT cycles.
   localparam logic [HOLD_CNT_W-1:0] TIMEOUT_LAST = HOLD_CNT_W'(SPAWN_TIMEOUT - 1);

   hold_state_t           state_q;
   logic                  hold_btn_q;
   logic                  hold_evt;
   logic [HOLD_CNT_W-1:0] cnt_q;
   tile_type_t            pending_q;
   tile_type_t            hold_type_q;
   tile_type_t            spawn_type_q;
   logic                  spawn_req_q;
   logic                  spawn_from_queue_q;
   logic                  hold_abort_q;
`ifdef HOLD_LOCKOUT_EN
   logic                  hold_used_q;
`endif

   assign hold_evt = hold_btn & ~hold_btn_q;

   // Button history for rising-edge detection; a held button yields one event.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         hold_btn_q <= 1'b0;
      end else if (game_clear) begin
         hold_btn_q <= 1'b0;
      end else begin
         hold_btn_q <= hold_btn;
      end
   end

   // Hold FSM with registered handshake, slot and status outputs.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         pending_q          <= BLANK;
         hold_type_q        <= BLANK;
         spawn_type_q       <= BLANK;
         spawn_req_q        <= 1'b0;
         spawn_from_queue_q <= 1'b0;
         hold_abort_q       <= 1'b0;
`ifdef HOLD_LOCKOUT_EN
         hold_used_q        <= 1'b0;
`endif
      end else if (game_clear) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         pending_q          <= BLANK;
         hold_type_q        <= BLANK;
         spawn_type_q       <= BLANK;
         spawn_req_q        <= 1'b0;
         spawn_from_queue_q <= 1'b0;
         hold_abort_q       <= 1'b0;
`ifdef HOLD_LOCKOUT_EN
         hold_used_q        <= 1'b0;
`endif
      end else begin
         hold_abort_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A lock on the same cycle as the edge wins; the hold is dropped.
               if (hold_evt && falling_valid && !piece_locked) begin
                  state_q     <= SPAWN;
                  cnt_q       <= '0;
                  pending_q   <= falling_type;
                  spawn_req_q <= 1'b1;
                  if (is_blank(hold_type_q)) begin
                     spawn_from_queue_q <= 1'b1;
                  end else begin
                     spawn_from_queue_q <= 1'b0;
                     spawn_type_q       <= hold_type_q;
                  end
               end
            end
            SPAWN: begin
               // Ack beats a timeout landing on the same cycle.
               if (spawn_ack) begin
                  hold_type_q <= pending_q;
                  spawn_req_q <= 1'b0;
`ifdef HOLD_LOCKOUT_EN
                  state_q     <= LOCKOUT;
                  hold_used_q <= 1'b1;
`else
                  state_q     <= IDLE;
`endif
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_q      <= IDLE;
                  spawn_req_q  <= 1'b0;
                  hold_abort_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            LOCKOUT: begin
`ifdef HOLD_LOCKOUT_EN
               if (piece_locked) begin
                  state_q     <= IDLE;
                  hold_used_q <= 1'b0;
               end
`else
               state_q <= IDLE;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign spawn_req        = spawn_req_q;
   assign spawn_from_queue = spawn_from_queue_q;
   assign spawn_type       = spawn_type_q;
   assign hold_piece_type  = hold_type_q;
   assign hold_abort       = hold_abort_q;
`ifdef HOLD_LOCKOUT_EN
   assign hold_used        = hold_used_q;
`else
   assign hold_used        = 1'b0;
`endif

endmodule

// File: tb/tb_hold_controller.sv
// Scoreboard bench for hold_controller (SPAWN_TIMEOUT = 4). Expected request
// start/end events are queued by the stimulus; a negedge monitor pops them.
module tb_hold_controller;
   import hold_controller_pkg::*;

`ifdef HOLD_LOCKOUT_EN
   localparam bit LK = 1'b1;
`else
   localparam bit LK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_l = 1'b0;
   logic       game_clear = 1'b0;
   logic       hold_btn = 1'b0;
   logic       falling_valid = 1'b0;
   tile_type_t falling_type = BLANK;
   logic       piece_locked = 1'b0;
   logic       spawn_ack = 1'b0;
   logic       spawn_req;
   logic       spawn_from_queue;
   tile_type_t spawn_type;
   tile_type_t hold_piece_type;
   logic       hold_used;
   logic       hold_abort;

   hold_controller #(.SPAWN_TIMEOUT(4)) dut (
      .clk              (clk),
      .rst_l            (rst_l),
      .game_clear       (game_clear),
      .hold_btn         (hold_btn),
      .falling_valid    (falling_valid),
      .falling_type     (falling_type),
      .piece_locked     (piece_locked),
      .spawn_ack        (spawn_ack),
      .spawn_req        (spawn_req),
      .spawn_from_queue (spawn_from_queue),
      .spawn_type       (spawn_type),
      .hold_piece_type  (hold_piece_type),
      .hold_used        (hold_used),
      .hold_abort       (hold_abort)
   );

   always #5 clk = ~clk;

   // kind 0 = request start (flag = spawn_from_queue), 1 = request end (flag = hold_abort)
   typedef struct {
      bit         kind;
      bit         flag;
      tile_type_t spawn_t;
      tile_type_t hold_t;
      bit         used;
      int         len;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  starts = 0;
   int  aborts = 0;
   int  req_len = 0;
   logic req_prev = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic exp_start(input bit fq, input tile_type_t st, input tile_type_t ht);
      ev_t e;
      e.kind = 1'b0; e.flag = fq; e.spawn_t = st; e.hold_t = ht; e.used = 1'b0; e.len = 0;
      exp_q.push_back(e);
   endtask

   task automatic exp_end(input bit ab, input tile_type_t ht, input bit used, input int len);
      ev_t e;
      e.kind = 1'b1; e.flag = ab; e.spawn_t = BLANK; e.hold_t = ht; e.used = used; e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic compare_ev(input ev_t g);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d flag=%0d spawn=%0d hold=%0d used=%0d len=%0d expected none",
                  g.kind, g.flag, g.spawn_t, g.hold_t, g.used, g.len);
      end else begin
         e = exp_q.pop_front();
         if (g.kind != e.kind || g.flag != e.flag || g.spawn_t != e.spawn_t ||
             g.hold_t != e.hold_t || g.used != e.used || g.len != e.len) begin
            errors++;
            $display("FAIL event: got kind=%0d flag=%0d spawn=%0d hold=%0d used=%0d len=%0d expected kind=%0d flag=%0d spawn=%0d hold=%0d used=%0d len=%0d",
                     g.kind, g.flag, g.spawn_t, g.hold_t, g.used, g.len,
                     e.kind, e.flag, e.spawn_t, e.hold_t, e.used, e.len);
         end
      end
   endtask

   // Monitor: request edges become events checked against the scoreboard.
   always @(negedge clk) begin
      ev_t g;
      if (spawn_req && !req_prev) begin
         req_len = 1;
         starts++;
         g.kind = 1'b0; g.flag = spawn_from_queue; g.spawn_t = spawn_type;
         g.hold_t = hold_piece_type; g.used = hold_used; g.len = 0;
         compare_ev(g);
      end else if (spawn_req) begin
         req_len++;
      end else if (req_prev) begin
         g.kind = 1'b1; g.flag = hold_abort; g.spawn_t = BLANK;
         g.hold_t = hold_piece_type; g.used = hold_used; g.len = req_len;
         compare_ev(g);
      end
      if (hold_abort) aborts++;
      req_prev = spawn_req;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic lock_pulse();
      piece_locked = 1'b1;
      cyc();
      piece_locked = 1'b0;
      cyc();
   endtask

   // Press the button once; ack in SPAWN cycle k (k = 0: never ack).
   task automatic swap(input int k);
      hold_btn = 1'b1;
      cyc();
      hold_btn = 1'b0;
      if (k > 0) begin
         repeat (k - 1) cyc();
         spawn_ack = 1'b1;
         cyc();
         spawn_ack = 1'b0;
         cyc();
         cyc();
      end else begin
         repeat (6) cyc();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      repeat (2) cyc();
      chk("rst_spawn_req", int'(spawn_req), 0);
      chk("rst_from_queue", int'(spawn_from_queue), 0);
      chk("rst_spawn_type", int'(spawn_type), int'(BLANK));
      chk("rst_hold_type", int'(hold_piece_type), int'(BLANK));
      chk("rst_hold_used", int'(hold_used), 0);
      chk("rst_hold_abort", int'(hold_abort), 0);
      rst_l = 1'b1;
      falling_valid = 1'b1;
      repeat (3) cyc();

      // empty hold, falling T, ack on 3rd request cycle
      falling_type = TILE_T;
      exp_start(1'b1, BLANK, BLANK);
      exp_end(1'b0, TILE_T, LK, 3);
      swap(3);
      chk("t1_hold_type", int'(hold_piece_type), int'(TILE_T));
      chk("t1_hold_used", int'(hold_used), int'(LK));

      // second edge during lockout is ignored
      falling_type = TILE_I;
`ifdef HOLD_LOCKOUT_EN
      hold_btn = 1'b1;
      cyc();
      hold_btn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("lockout_no_req", int'(spawn_req), 0);
      end
`endif
      lock_pulse();
      chk("after_lock_used", int'(hold_used), 0);

      // held T, falling I, immediate ack
      exp_start(1'b0, TILE_T, TILE_T);
      exp_end(1'b0, TILE_I, LK, 1);
      swap(1);
      chk("t2_hold_type", int'(hold_piece_type), int'(TILE_I));
      lock_pulse();

      // timeout: request high exactly 4 cycles, abort, slot unchanged
      falling_type = TILE_S;
      exp_start(1'b0, TILE_I, TILE_I);
      exp_end(1'b1, TILE_I, 1'b0, 4);
      swap(0);
      chk("timeout_hold_type", int'(hold_piece_type), int'(TILE_I));
      chk("timeout_abort_low", int'(hold_abort), 0);
      lock_pulse();

      // ack on the last allowed cycle commits
      exp_start(1'b0, TILE_I, TILE_I);
      exp_end(1'b0, TILE_S, LK, 4);
      swap(4);
      chk("late_ack_hold_type", int'(hold_piece_type), int'(TILE_S));
      lock_pulse();

      // lock coincident with hold edge in IDLE: no request
      falling_type = TILE_Z;
      hold_btn = 1'b1;
      piece_locked = 1'b1;
      cyc();
      piece_locked = 1'b0;
      hold_btn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("coincident_no_req", int'(spawn_req), 0);
      end
      chk("coincident_hold_type", int'(hold_piece_type), int'(TILE_S));

      // button held 50 cycles: exactly one swap
      exp_start(1'b0, TILE_S, TILE_S);
      exp_end(1'b0, TILE_Z, LK, 2);
      hold_btn = 1'b1;
      cyc();
      cyc();
      spawn_ack = 1'b1;
      cyc();
      spawn_ack = 1'b0;
      repeat (47) cyc();
      hold_btn = 1'b0;
      cyc();
      chk("held_btn_hold_type", int'(hold_piece_type), int'(TILE_Z));
      lock_pulse();

      // asynchronous reset in the middle of a request
      falling_type = TILE_O;
      exp_start(1'b0, TILE_Z, TILE_Z);
      exp_end(1'b0, BLANK, 1'b0, 1);
      hold_btn = 1'b1;
      cyc();
      hold_btn = 1'b0;
      cyc();
      #2;
      rst_l = 1'b0;
      #1;
      chk("arst_spawn_req", int'(spawn_req), 0);
      chk("arst_hold_type", int'(hold_piece_type), int'(BLANK));
      chk("arst_from_queue", int'(spawn_from_queue), 0);
      chk("arst_spawn_type", int'(spawn_type), int'(BLANK));
      cyc();
      rst_l = 1'b1;
      repeat (2) cyc();

      // game_clear after a swap returns to an empty, accepting slot
      falling_type = TILE_J;
      exp_start(1'b1, BLANK, BLANK);
      exp_end(1'b0, TILE_J, LK, 1);
      swap(1);
      game_clear = 1'b1;
      cyc();
      game_clear = 1'b0;
      chk("clear_hold_type", int'(hold_piece_type), int'(BLANK));
      chk("clear_hold_used", int'(hold_used), 0);
      chk("clear_from_queue", int'(spawn_from_queue), 0);
      falling_type = TILE_L;
      exp_start(1'b1, BLANK, BLANK);
      exp_end(1'b0, TILE_L, LK, 2);
      swap(2);
      chk("post_clear_hold_type", int'(hold_piece_type), int'(TILE_L));

      repeat (5) cyc();
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("request_count", starts, 8);
      chk("abort_count", aborts, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
